// File: rtl/fcvt_s_w_pipe.sv
// -----------------------------------------------------------------------------
// fcvt_s_w_pipe
//   Handshaked integer-to-float converter (FCVT.S.W / FCVT.S.WU class).
//   Converts an XLEN-bit signed or unsigned integer into an IEEE-754 binary
//   float {sign, EXP_W exponent, MAN_W mantissa}, correctly rounded, with an
//   inexact flag. Sequenced by a four-state FSM: IDLE -> CALC -> RND -> DONE.
//
// Parameters
//   XLEN   integer operand width (8..64)
//   EXP_W  exponent width (bias = 2^(EXP_W-1)-1). Must satisfy XLEN <= 2^(EXP_W-1)
//   MAN_W  stored mantissa width
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   in_valid       request valid
//   in_ready       request accepted when high (FSM idle)
//   in_data        integer operand
//   in_unsigned    1: operand unsigned, 0: two's complement
//   in_rm          rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM,
//                  others RNE)
//   out_valid      result valid, held until out_ready
//   out_ready      consumer accepts result
//   out_data       {sign, exponent, mantissa}; keeps last value after handshake
//   out_nx         inexact flag for out_data
//   busy           conversion in progress (not idle)
//
// Configuration
//   FCVT_ROUND_MODES_EN  defined: in_rm fully decoded.
//                        undefined: in_rm ignored, RNE always applied.
// -----------------------------------------------------------------------------
module fcvt_s_w_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_data,
  input  logic                   in_unsigned,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_nx,
  output logic                   busy
);

  localparam int unsigned LZW  = $clog2(XLEN + 1);
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  // Normalised fraction (leading one dropped) padded with MAN_W+1 zeros so
  // kept/guard bits exist even when XLEN-1 < MAN_W.
  localparam int unsigned EXTW = XLEN + MAN_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RND,
    S_DONE
  } state_t;

`ifdef FCVT_ROUND_MODES_EN
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_t;

  rm_t rm_q;
`else
  logic unused_rm;
  assign unused_rm = ^in_rm;
`endif

  state_t            state;
  logic [XLEN-1:0]   data_q;
  logic              uns_q;
  logic              sign_q;
  logic              zero_q;
  logic [LZW-1:0]    lz_q;
  logic [XLEN-2:0]   norm_q;

  // CALC stage combinational signals
  logic              calc_sign;
  logic [XLEN-1:0]   calc_mag;
  logic [LZW-1:0]    calc_lz;
  logic [XLEN-2:0]   calc_norm;
  logic              norm_msb_unused;

  // RND stage combinational signals
  logic [EXTW-1:0]   ext;
  logic [MAN_W-1:0]  kept;
  logic              g_bit;
  logic              s_bit;
  logic              rnd_inexact;
  logic              inc;
  logic [MAN_W:0]    mant_sum;
  logic [EXP_W-1:0]  exp_base;
  logic [EXP_W-1:0]  rnd_exp;
  logic [EXP_W+MAN_W:0] rnd_data;
  logic              rnd_nx;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    calc_sign = ~uns_q & data_q[XLEN-1];
    calc_mag  = calc_sign ? (~data_q + 1'b1) : data_q;
    // Priority encoder: the highest set bit is visited last and wins.
    calc_lz = LZW'(XLEN);
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (calc_mag[i]) calc_lz = LZW'(XLEN - 1 - i);
    end
    {norm_msb_unused, calc_norm} = calc_mag << calc_lz;
  end

  always_comb begin
    ext         = {norm_q, {(MAN_W + 1){1'b0}}};
    kept        = ext[EXTW-1 -: MAN_W];
    g_bit       = ext[XLEN-1];
    s_bit       = |ext[XLEN-2:0];
    rnd_inexact = g_bit | s_bit;
`ifdef FCVT_ROUND_MODES_EN
    case (rm_q)
      RM_RNE:  inc = g_bit & (s_bit | kept[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & rnd_inexact;
      RM_RUP:  inc = ~sign_q & rnd_inexact;
      RM_RMM:  inc = g_bit;
      default: inc = g_bit & (s_bit | kept[0]);
    endcase
`else
    inc = g_bit & (s_bit | kept[0]);
`endif
    mant_sum = {1'b0, kept} + (MAN_W + 1)'(inc);
    exp_base = EXP_W'(BIAS + XLEN - 1) - EXP_W'(lz_q);
    // Mantissa carry-out leaves the low bits at zero; only the exponent moves.
    rnd_exp  = exp_base + EXP_W'(mant_sum[MAN_W]);
    rnd_data = zero_q ? '0 : {sign_q, rnd_exp, mant_sum[MAN_W-1:0]};
    rnd_nx   = zero_q ? 1'b0 : rnd_inexact;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      data_q    <= '0;
      uns_q     <= 1'b0;
`ifdef FCVT_ROUND_MODES_EN
      rm_q      <= RM_RNE;
`endif
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      lz_q      <= '0;
      norm_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nx    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            uns_q  <= in_unsigned;
`ifdef FCVT_ROUND_MODES_EN
            rm_q   <= (in_rm > 3'd4) ? RM_RNE : rm_t'(in_rm);
`endif
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          sign_q <= calc_sign;
          zero_q <= (calc_mag == '0);
          lz_q   <= calc_lz;
          norm_q <= calc_norm;
          state  <= S_RND;
        end
        S_RND: begin
          out_data  <= rnd_data;
          out_nx    <= rnd_nx;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
